ex_div_iter: RTL

// - Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// - Produces stallreq_for_ex for the pipeline stall controller: EX (and all earlier stages) freeze

---
 rtl/ex_div_iter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ex_div_iter.sv
// ex_div_iter
//   Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
//   One quotient bit is produced per cycle, so a result is available
//   DATA_W+1 cycles after the operation is accepted (two cycles for a
//   zero divisor). While a division is in flight stallreq_for_ex freezes
//   EX and all earlier stages; the result is consumed on the ready edge.
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous, active-high reset
//   start            EX holds a DIV/DIVU (held high by the stall until ready)
//   signed_div       1 = DIV (two's complement), 0 = DIVU
//   dividend         rs operand, sampled only on acceptance
//   divisor          rt operand, sampled only on acceptance
//   annul            abort any in-flight operation (exception/flush)
//   result           {remainder (HI), quotient (LO)}; meaningful while ready=1
//   ready            one-cycle pulse marking a valid result
//   stallreq_for_ex  combinational stall request: start & ~ready
module ex_div_iter #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                signed_div,
  input  logic [DATA_W-1:0]   dividend,
  input  logic [DATA_W-1:0]   divisor,
  input  logic                annul,
  output logic [2*DATA_W-1:0] result,
  output logic                ready,
  output logic                stallreq_for_ex
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DZERO,
    FIN
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rem;      // partial remainder
  logic [DATA_W-1:0] quo;      // dividend bits shifting out, quotient bits shifting in
  logic [DATA_W-1:0] dvs;      // divisor magnitude
  logic              neg_q;
  logic              neg_r;

  logic              div_zero;
  logic              last_iter;
  logic [DATA_W-1:0] dd_mag;
  logic [DATA_W-1:0] dv_mag;

  logic [DATA_W:0]   shifted;
  logic              trial_ok;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] rem_step;
  logic [DATA_W-1:0] quo_step;
  logic [DATA_W-1:0] q_fix;
  logic [DATA_W-1:0] r_fix;

  // Operand magnitudes. For the most negative value the negation wraps to
  // itself, which is the correct unsigned magnitude.
  always_comb begin
    div_zero = (divisor == '0);
    dd_mag   = (signed_div && dividend[DATA_W-1]) ? -dividend : dividend;
    dv_mag   = (signed_div && divisor[DATA_W-1])  ? -divisor  : divisor;
  end

  // One restoring step. The shifted remainder needs DATA_W+1 bits, but a
  // successful trial always leaves a value below the divisor, so the low
  // DATA_W bits of the modular difference are exact.
  always_comb begin
    shifted   = {rem, quo[DATA_W-1]};
    trial_ok  = (shifted >= {1'b0, dvs});
    diff      = shifted[DATA_W-1:0] - dvs;
    rem_step  = trial_ok ? diff : shifted[DATA_W-1:0];
    quo_step  = {quo[DATA_W-2:0], trial_ok};
    q_fix     = neg_q ? -quo_step : quo_step;
    r_fix     = neg_r ? -rem_step : rem_step;
    last_iter = (cnt == CNT_W'(DATA_W - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (annul) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (start) state_nx = div_zero ? DZERO : RUN;
        RUN:   if (last_iter) state_nx = FIN;
        DZERO: state_nx = FIN;
        FIN:   state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Datapath. The final step and its sign correction are folded into the
  // last RUN edge so that result is already registered in the FIN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      ready  <= 1'b0;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (annul) begin
        cnt <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !div_zero) begin
              quo   <= dd_mag;
              dvs   <= dv_mag;
              rem   <= '0;
              cnt   <= '0;
              neg_q <= signed_div & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
              neg_r <= signed_div & dividend[DATA_W-1];
            end
          end
          RUN: begin
            rem <= rem_step;
            quo <= quo_step;
            cnt <= cnt + 1'b1;
            if (last_iter) begin
              result <= {r_fix, q_fix};
              ready  <= 1'b1;
            end
          end
          DZERO: begin
            result <= '0;
            ready  <= 1'b1;
          end
          FIN: begin
            cnt <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign stallreq_for_ex = start & ~ready;

endmodule
